// File: rtl/mc_pkg.sv
// Shared opcodes, ALU codes and FSM state encodings for the multicycle control path.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_EXEC_I = 4'd3;
  localparam logic [3:0] S_EXEC_M = 4'd4;
  localparam logic [3:0] S_MEM_RD = 4'd5;
  localparam logic [3:0] S_MEM_WR = 4'd6;
  localparam logic [3:0] S_WB_ALU = 4'd7;
  localparam logic [3:0] S_WB_MEM = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_ERR    = 4'd10;

  function automatic logic is_itype(input logic [5:0] op);
    return (op == OP_LI) || (op == OP_LUI) || (op == OP_ADDI) ||
           (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic logic [3:0] itype_alu(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ack_timer.sv
// Counts cycles spent waiting for a data-memory ack; expired marks the last allowed cycle.
module mc_ack_timer #(
  parameter int ACK_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)       cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + TO_W'(1);
  end

  assign expired = (cnt == TO_W'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/mc_control.sv
// Multicycle control FSM for fetch/decode/exec/mem/writeback sequencing.
// Optional MC_CONTROL_PERF_EN adds cycle and retired-instruction counters.
module mc_control
  import mc_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Func,
  input  logic       Zero,
  input  logic       Mem_Ack,
  output logic       PC_sel,
  output logic       PC_LdEn,
  output logic       IR_LdEn,
  output logic       RF_WrEn,
  output logic       RF_B_sel,
  output logic       RF_WrData_sel,
  output logic       ALU_Bin_sel,
  output logic [3:0] ALU_func,
  output logic       Mem_RdEn,
  output logic       Mem_WrEn,
  output logic       Err
`ifdef MC_CONTROL_PERF_EN
  ,
  output logic [31:0] Cycle_Cnt,
  output logic [31:0] Instr_Cnt
`endif
);

  logic [3:0] state, state_nxt;
  logic       in_mem, expired;
  logic       func_unused;

  assign func_unused = ^Func[5:4];
  assign in_mem      = (state == S_MEM_RD) || (state == S_MEM_WR);

  mc_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT), .TO_W(TO_W)) u_timer (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear   (~in_mem | Mem_Ack),
    .enable  (in_mem & ~Mem_Ack),
    .expired (expired)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        if (Opcode == OP_RTYPE)                     state_nxt = S_EXEC_R;
        else if (is_itype(Opcode))                  state_nxt = S_EXEC_I;
        else if (Opcode == OP_LW || Opcode == OP_SW) state_nxt = S_EXEC_M;
        else if (Opcode == OP_B || Opcode == OP_BEQ || Opcode == OP_BNE)
                                                    state_nxt = S_BRANCH;
        else                                        state_nxt = S_ERR;
      end
      S_EXEC_R, S_EXEC_I: state_nxt = S_WB_ALU;
      S_EXEC_M: state_nxt = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (Mem_Ack)      state_nxt = S_WB_MEM;
        else if (expired) state_nxt = S_ERR;
      end
      S_MEM_WR: begin
        if (Mem_Ack)      state_nxt = S_FETCH;
        else if (expired) state_nxt = S_ERR;
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH: state_nxt = S_FETCH;
      S_ERR:    state_nxt = S_ERR;
      default:  state_nxt = S_ERR;
    endcase
  end

  // Reset state is FETCH, so gate its IR load to keep every enable low while Reset is held.
  assign IR_LdEn = (state == S_FETCH) & ~Reset;
  assign Err     = (state == S_ERR);

  always_comb begin
    PC_sel        = 1'b0;
    PC_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_B_sel      = 1'b0;
    RF_WrData_sel = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = ALU_ADD;
    Mem_RdEn      = 1'b0;
    Mem_WrEn      = 1'b0;
    case (state)
      S_DECODE: RF_B_sel = is_itype(Opcode) || (Opcode == OP_SW);
      S_EXEC_R: ALU_func = Func[3:0];
      S_EXEC_I: begin
        ALU_Bin_sel = 1'b1;
        ALU_func    = itype_alu(Opcode);
      end
      S_EXEC_M: ALU_Bin_sel = 1'b1;
      S_MEM_RD: Mem_RdEn = 1'b1;
      // A store retires in its ack cycle, so the PC load rides on Mem_Ack.
      S_MEM_WR: begin
        Mem_WrEn = 1'b1;
        PC_LdEn  = Mem_Ack;
      end
      S_WB_ALU: begin
        RF_WrEn = 1'b1;
        PC_LdEn = 1'b1;
      end
      S_WB_MEM: begin
        RF_WrEn       = 1'b1;
        RF_WrData_sel = 1'b1;
        PC_LdEn       = 1'b1;
      end
      S_BRANCH: begin
        ALU_func = ALU_SUB;
        PC_LdEn  = 1'b1;
        PC_sel   = (Opcode == OP_B) || ((Opcode == OP_BEQ) && Zero) ||
                   ((Opcode == OP_BNE) && !Zero);
      end
      default: ;
    endcase
  end

`ifdef MC_CONTROL_PERF_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Cycle_Cnt <= '0;
      Instr_Cnt <= '0;
    end else begin
      if (state != S_ERR) Cycle_Cnt <= Cycle_Cnt + 32'd1;
      if (PC_LdEn)        Instr_Cnt <= Instr_Cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed scenarios plus a random instruction stream,
// each checked cycle by cycle against per-instruction-class expected output sequences.
module tb_mc_control;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [5:0] Opcode, Func;
  logic       Zero, Mem_Ack;
  logic       PC_sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_B_sel, RF_WrData_sel, ALU_Bin_sel;
  logic [3:0] ALU_func;
  logic       Mem_RdEn, Mem_WrEn, Err;
`ifdef MC_CONTROL_PERF_EN
  logic [31:0] Cycle_Cnt, Instr_Cnt;
  logic [31:0] exp_cyc, exp_ins;
`endif

  typedef struct packed {
    logic       pc_sel, pc_ld, ir_ld, rf_wr, rf_bsel, rf_wdsel, alu_bin;
    logic [3:0] alu_func;
    logic       mem_rd, mem_wr, err;
  } ov_t;

  int total = 0;
  int bad   = 0;

  // Opcode values written independently from the instruction-set table.
  logic [5:0] legal [11] = '{6'b100000, 6'b111000, 6'b111001, 6'b110000, 6'b110010,
                             6'b110011, 6'b001111, 6'b011111, 6'b111111, 6'b000000,
                             6'b000001};

  mc_control dut (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Func(Func), .Zero(Zero),
    .Mem_Ack(Mem_Ack), .PC_sel(PC_sel), .PC_LdEn(PC_LdEn), .IR_LdEn(IR_LdEn),
    .RF_WrEn(RF_WrEn), .RF_B_sel(RF_B_sel), .RF_WrData_sel(RF_WrData_sel),
    .ALU_Bin_sel(ALU_Bin_sel), .ALU_func(ALU_func), .Mem_RdEn(Mem_RdEn),
    .Mem_WrEn(Mem_WrEn), .Err(Err)
`ifdef MC_CONTROL_PERF_EN
    , .Cycle_Cnt(Cycle_Cnt), .Instr_Cnt(Instr_Cnt)
`endif
  );

  always #5 Clk = ~Clk;

  function automatic ov_t observe();
    return {PC_sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_B_sel, RF_WrData_sel, ALU_Bin_sel,
            ALU_func, Mem_RdEn, Mem_WrEn, Err};
  endfunction

  function automatic logic is_imm(input logic [5:0] op);
    return op inside {6'b111000, 6'b111001, 6'b110000, 6'b110010, 6'b110011};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    foreach (legal[i]) if (legal[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive Mem_Ack, compare at the falling edge, advance past the rising edge.
  task automatic step(input ov_t e, input logic ack, input string tag);
    ov_t o;
    Mem_Ack = ack;
    @(negedge Clk);
    o = observe();
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
`ifdef MC_CONTROL_PERF_EN
    total++;
    assert (Cycle_Cnt === exp_cyc) else begin
      bad++;
      $error("FAIL %s cycle_cnt observed=%0d expected=%0d", tag, Cycle_Cnt, exp_cyc);
    end
    total++;
    assert (Instr_Cnt === exp_ins) else begin
      bad++;
      $error("FAIL %s instr_cnt observed=%0d expected=%0d", tag, Instr_Cnt, exp_ins);
    end
`endif
    @(posedge Clk);
`ifdef MC_CONTROL_PERF_EN
    if (!e.err)  exp_cyc++;
    if (e.pc_ld) exp_ins++;
`endif
    #1;
  endtask

  task automatic do_reset(input string tag);
    ov_t o;
    #1 Reset = 1'b1;
    #1 o = observe();
    total++;
    assert (o === ov_t'(0)) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, ov_t'(0));
    end
    @(posedge Clk);
    #1 Reset = 1'b0;
`ifdef MC_CONTROL_PERF_EN
    exp_cyc = 0;
    exp_ins = 0;
`endif
  endtask

  // Expected cycle sequence for one instruction, derived from its class.
  // dly = index of the memory wait cycle carrying Mem_Ack; >= 16 means no ack.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int dly, output logic went_err);
    ov_t e;
    Opcode = op; Func = fn; Zero = z;
    went_err = 1'b0;
    e = '0; e.ir_ld = 1'b1;
    step(e, 1'($urandom_range(0, 1)), "fetch");
    e = '0; e.rf_bsel = is_imm(op) || (op == 6'b011111);
    step(e, 1'($urandom_range(0, 1)), "decode");
    if (op == 6'b100000 || is_imm(op)) begin
      e = '0;
      if (op == 6'b100000) e.alu_func = fn[3:0];
      else begin
        e.alu_bin  = 1'b1;
        e.alu_func = (op == 6'b110010) ? 4'd2 : (op == 6'b110011) ? 4'd3 : 4'd0;
      end
      step(e, 1'($urandom_range(0, 1)), "exec");
      e = '0; e.rf_wr = 1'b1; e.pc_ld = 1'b1;
      step(e, 1'($urandom_range(0, 1)), "wb_alu");
    end else if (op == 6'b001111 || op == 6'b011111) begin
      e = '0; e.alu_bin = 1'b1;
      step(e, 1'($urandom_range(0, 1)), "exec_m");
      for (int k = 0; k < 16; k++) begin
        e = '0;
        if (op == 6'b001111) e.mem_rd = 1'b1;
        else begin
          e.mem_wr = 1'b1;
          e.pc_ld  = (k == dly);
        end
        step(e, k == dly, "mem_wait");
        if (k == dly) break;
      end
      if (dly >= 16) begin
        e = '0; e.err = 1'b1;
        step(e, 1'($urandom_range(0, 1)), "timeout_err");
        went_err = 1'b1;
      end else if (op == 6'b001111) begin
        e = '0; e.rf_wr = 1'b1; e.rf_wdsel = 1'b1; e.pc_ld = 1'b1;
        step(e, 1'($urandom_range(0, 1)), "wb_mem");
      end
    end else if (op == 6'b111111 || op == 6'b000000 || op == 6'b000001) begin
      e = '0; e.alu_func = 4'd1; e.pc_ld = 1'b1;
      e.pc_sel = (op == 6'b111111) ? 1'b1 : (op == 6'b000000) ? z : ~z;
      step(e, 1'($urandom_range(0, 1)), "branch");
    end else begin
      e = '0; e.err = 1'b1;
      step(e, 1'($urandom_range(0, 1)), "illegal_err");
      went_err = 1'b1;
    end
  endtask

  task automatic err_hold_and_reset();
    ov_t e;
    e = '0; e.err = 1'b1;
    for (int k = 0; k < 3; k++) begin
      Opcode = 6'($urandom); Zero = 1'($urandom);
      step(e, 1'($urandom_range(0, 1)), "err_hold");
    end
    do_reset("err_reset");
  endtask

  initial begin
    logic werr;
    ov_t  e;
    Reset = 1'b1; Opcode = '0; Func = '0; Zero = 1'b0; Mem_Ack = 1'b0;
`ifdef MC_CONTROL_PERF_EN
    exp_cyc = 0; exp_ins = 0;
`endif
    @(negedge Clk);
    total++;
    assert (observe() === ov_t'(0)) else begin
      bad++;
      $error("FAIL reset_state observed=%h expected=%h", observe(), ov_t'(0));
    end
    @(posedge Clk);
    #1 Reset = 1'b0;

    // Directed: R-type, beq/bne with Zero=1, lw with 3 wait cycles.
    run_instr(6'b100000, 6'b000011, 1'b0, 0, werr);
    run_instr(6'b000000, 6'b000000, 1'b1, 0, werr);
    run_instr(6'b000001, 6'b000000, 1'b1, 0, werr);
    run_instr(6'b001111, 6'b000000, 1'b0, 3, werr);
    run_instr(6'b011111, 6'b000000, 1'b0, 0, werr);

    // Store with no ack: 16 wait cycles then ERR until reset.
    run_instr(6'b011111, 6'b000000, 1'b0, 16, werr);
    err_hold_and_reset();

    // Illegal opcode after some retirements.
    run_instr(6'b110000, 6'b000000, 1'b0, 0, werr);
    run_instr(6'b111111, 6'b000000, 1'b0, 0, werr);
    run_instr(6'b101010, 6'b000000, 1'b0, 0, werr);
    err_hold_and_reset();

    // Reset mid-store: Mem_WrEn must drop without waiting for a clock edge.
    Opcode = 6'b011111;
    e = '0; e.ir_ld = 1'b1;                 step(e, 1'b1, "mid_fetch");
    e = '0; e.rf_bsel = 1'b1;               step(e, 1'b0, "mid_decode");
    e = '0; e.alu_bin = 1'b1;               step(e, 1'b0, "mid_exec_m");
    e = '0; e.mem_wr = 1'b1;                step(e, 1'b0, "mid_mem_wr");
    Mem_Ack = 1'b0;
    #1 total++;
    assert (Mem_WrEn === 1'b1) else begin
      bad++;
      $error("FAIL mid_wr_before_reset observed=%b expected=1", Mem_WrEn);
    end
    do_reset("mid_wr_reset");
    run_instr(6'b100000, 6'b000101, 1'b0, 0, werr);

    // Random instruction stream.
    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      int         dly;
      if ($urandom_range(0, 15) == 0) begin
        op = 6'($urandom);
        if (is_legal(op)) op = 6'b010101;
      end else begin
        op = legal[$urandom_range(0, 10)];
      end
      dly = ($urandom_range(0, 11) == 0) ? 16 : $urandom_range(0, 4);
      run_instr(op, 6'($urandom), 1'($urandom), dly, werr);
      if (werr) err_hold_and_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
